// File: rtl/sequential_read_pkg.sv
// rtl/sequential_read_pkg.sv - shared record-read constants and FSM encoding
package sequential_read_pkg;

  localparam int unsigned DEFAULT_RECORD_LEN = 8;
  localparam int unsigned DEFAULT_ADDR_W     = 12;

  // A NUL byte terminates a record early.
  localparam logic [7:0] NUL_CHAR = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_PRESENT,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/sequential_read.sv
// rtl/sequential_read.sv - reads one fixed-stride record from character RAM and streams it out
module sequential_read
  import sequential_read_pkg::*;
#(
  parameter int unsigned RECORD_LEN = DEFAULT_RECORD_LEN,
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] begin_at,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_q,
  output logic [7:0]        char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              done,
  output logic [3:0]        count,
  output logic [ADDR_W-1:0] next_addr
);

  localparam int unsigned       IDX_W  = $clog2(RECORD_LEN + 1);
  localparam logic [IDX_W-1:0]  IDX_END = IDX_W'(RECORD_LEN);
  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(RECORD_LEN);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [IDX_W-1:0]  index_inc;
  logic [3:0]        count_q, count_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        char_out_q, char_out_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      index_q     <= '0;
      count_q     <= '0;
      next_addr_q <= '0;
      mem_addr_q  <= '0;
      char_out_q  <= NUL_CHAR;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      index_q     <= index_d;
      count_q     <= count_d;
      next_addr_q <= next_addr_d;
      mem_addr_q  <= mem_addr_d;
      char_out_q  <= char_out_d;
    end
  end

  // mem_addr is loaded on entry to ISSUE so the RAM sees it for the whole ISSUE cycle.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    index_d     = index_q;
    count_d     = count_q;
    next_addr_d = next_addr_q;
    mem_addr_d  = mem_addr_q;
    char_out_d  = char_out_q;
    index_inc   = index_q + IDX_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d      = begin_at;
          index_d     = '0;
          count_d     = '0;
          next_addr_d = begin_at + STRIDE;
          mem_addr_d  = begin_at;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        char_out_d = mem_q;
        state_d    = (mem_q == NUL_CHAR) ? ST_FINISH : ST_PRESENT;
      end
      ST_PRESENT: begin
        if (char_ready) begin
          count_d = count_q + 4'd1;
          index_d = index_inc;
          if (index_inc == IDX_END) begin
            state_d = ST_FINISH;
          end else begin
            mem_addr_d = base_q + ADDR_W'(index_inc);
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_addr   = mem_addr_q;
  assign char_out   = char_out_q;
  assign char_valid = (state_q == ST_PRESENT);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FINISH);
  assign count      = count_q;
  assign next_addr  = next_addr_q;

endmodule

// File: tb/tb_sequential_read.sv
// tb/tb_sequential_read.sv - randomized scoreboard bench for sequential_read
module tb_sequential_read;

  localparam int RL = 8;
  localparam int AW = 12;

  typedef struct {
    logic [7:0]    ch;
    logic [AW-1:0] addr;
    int            idx;
  } exp_char_t;

  typedef struct {
    int            cnt;
    logic [AW-1:0] nxt;
  } exp_rec_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] begin_at;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_q;
  logic [7:0]    char_out;
  logic          char_valid;
  logic          char_ready;
  logic          busy;
  logic          done;
  logic [3:0]    count;
  logic [AW-1:0] next_addr;

  sequential_read #(.RECORD_LEN(RL), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .begin_at   (begin_at),
    .mem_addr   (mem_addr),
    .mem_q      (mem_q),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .next_addr  (next_addr)
  );

  logic [7:0] ram [0:(1<<AW)-1];
  exp_char_t  char_q[$];
  exp_rec_t   rec_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_acc = 0;
  int acc_in_rec = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int stall_cnt = 0;
  logic       held = 1'b0;
  logic [7:0] held_char = 8'h00;
  exp_char_t  e;
  exp_rec_t   r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_q <= ram[mem_addr];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // 0: always ready, 1: random, 2: stall the second character for five cycles
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: char_ready = 1'b1;
      1: char_ready = 1'($urandom_range(0, 1));
      default: begin
        if (char_valid && acc_in_rec == 1 && stall_cnt < 5) begin
          char_ready = 1'b0;
          stall_cnt++;
        end else begin
          char_ready = 1'b1;
        end
      end
    endcase
  end

  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (char_valid) begin
        if (held) check("hold_stable", int'(char_out), int'(held_char));
        if (char_ready) begin
          n_checks++;
          if (char_q.size() == 0) begin
            $display("FAIL unexpected_char: got %02h expected no character", char_out);
          end else begin
            n_pass++;
            e = char_q.pop_front();
            check("char_data", int'(char_out), int'(e.ch));
            check("char_addr", int'(mem_addr), int'(e.addr));
            if (ready_mode == 0 && e.idx != 0) check("char_gap", cyc - last_acc, 3);
          end
          last_acc = cyc;
          acc_in_rec++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_char = char_out;
        end
      end else begin
        held = 1'b0;
      end
      if (done) begin
        n_checks++;
        if (rec_q.size() == 0) begin
          $display("FAIL unexpected_done: got done expected none");
        end else begin
          n_pass++;
          r = rec_q.pop_front();
          check("count", int'(count), r.cnt);
          check("next_addr", int'(next_addr), int'(r.nxt));
          check("chars_left", char_q.size(), 0);
        end
        done_cnt++;
      end
    end
  end

  // Reference: walk the record slots in RAM, stopping at the first NUL.
  task automatic model_record(input logic [AW-1:0] base);
    int n;
    logic [AW-1:0] a;
    exp_char_t x;
    exp_rec_t  y;
    n = 0;
    for (int i = 0; i < RL; i++) begin
      a = AW'((int'(base) + i) % (1 << AW));
      if (ram[a] == 8'h00) break;
      x.ch = ram[a];
      x.addr = a;
      x.idx = i;
      char_q.push_back(x);
      n++;
    end
    y.cnt = n;
    y.nxt = AW'((int'(base) + RL) % (1 << AW));
    rec_q.push_back(y);
  endtask

  task automatic issue_start(input logic [AW-1:0] base);
    acc_in_rec = 0;
    stall_cnt = 0;
    model_record(base);
    begin_at = base;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_accepted", int'(busy), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) @(posedge clk);
    check("idle_before_start", int'(busy), 0);
    @(negedge clk);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(posedge clk);
    check("record_done", done_cnt - d0, 1);
  endtask

  task automatic run_record(input logic [AW-1:0] base);
    int d0;
    wait_idle();
    d0 = done_cnt;
    issue_start(base);
    wait_done(d0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_char_valid"}, int'(char_valid), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_char_out"}, int'(char_out), 0);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_next_addr"}, int'(next_addr), 0);
  endtask

  task automatic fill_nonzero(input int base, input int n);
    for (int i = 0; i < n; i++) ram[(base + i) % (1 << AW)] = 8'($urandom_range(1, 255));
  endtask

  initial begin
    int d0;
    int found;
    string s;
    reset = 1'b1;
    start = 1'b0;
    begin_at = '0;
    char_ready = 1'b1;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'($urandom_range(1, 255));
    #1;
    check_reset_outputs("reset_state");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Full record "ABCDEFGH" with constant ready
    s = "ABCDEFGH";
    for (int i = 0; i < 8; i++) ram[12'h010 + i] = s[i];
    ready_mode = 0;
    run_record(12'h010);

    // Early NUL after "HI"
    ram[12'h020] = "H";
    ram[12'h021] = "I";
    ram[12'h022] = 8'h00;
    run_record(12'h020);

    // Backpressure on the second character
    ready_mode = 2;
    fill_nonzero(12'h080, RL);
    run_record(12'h080);
    check("stall_cycles", stall_cnt, 5);

    // Address wrap
    ready_mode = 0;
    fill_nonzero(12'hFFC, RL);
    run_record(12'hFFC);

    // Start while busy is ignored
    fill_nonzero(12'h040, RL);
    fill_nonzero(12'h300, RL);
    wait_idle();
    d0 = done_cnt;
    issue_start(12'h040);
    repeat (5) @(posedge clk);
    #1;
    begin_at = 12'h300;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d0);

    // Reset during the third PRESENT
    fill_nonzero(12'h100, RL);
    fill_nonzero(12'h200, RL);
    wait_idle();
    issue_start(12'h100);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(posedge clk);
      #2;
      if (char_valid && acc_in_rec == 2) found = 1;
    end
    check("reached_third_present", found, 1);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    char_q.delete();
    rec_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("no_done_on_reset", done_cnt, d0);
    issue_start(12'h200);
    wait_done(d0);

    // Random records with random ready and occasional early NUL
    ready_mode = 1;
    for (int k = 0; k < 8; k++) begin
      logic [AW-1:0] b;
      b = AW'($urandom_range(0, (1 << AW) - 1));
      fill_nonzero(int'(b), RL);
      if ($urandom_range(0, 3) == 0) ram[(int'(b) + $urandom_range(0, RL - 1)) % (1 << AW)] = 8'h00;
      run_record(b);
    end

    repeat (5) @(posedge clk);
    check("char_queue_empty", char_q.size(), 0);
    check("rec_queue_empty", rec_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sequential_read.md
SEQUENTIAL_READ -- requirements
Module: sequential_read

Interface
REQ-001 Parameter RECORD_LEN, default 8, is the number of character slots per record and the address stride.
REQ-002 Parameter ADDR_W, default 12, is the memory address width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to read one record; sampled only in IDLE.
REQ-006 begin_at  input  ADDR_W  record base address; captured when start is accepted.
REQ-007 mem_addr  output  ADDR_W  read address to the character RAM.
REQ-008 mem_q  input  8  RAM read data; valid exactly one cycle after mem_addr is driven.
REQ-009 char_out  output  8  ASCII character presented downstream.
REQ-010 char_valid  output  1  char_out holds a valid character.
REQ-011 char_ready  input  1  downstream accepts char_out when high together with char_valid.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when the record ends.
REQ-014 count  output  4  characters delivered in the last record; held until the next start.
REQ-015 next_addr  output  ADDR_W  begin_at + RECORD_LEN modulo 2^ADDR_W; held until the next start.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, CAPTURE, PRESENT and FINISH.
REQ-017 IDLE with start=1 SHALL latch begin_at, clear the slot index and count, compute next_addr, and go to ISSUE.
REQ-018 ISSUE SHALL drive mem_addr = base + index (mod 2^ADDR_W) and go to CAPTURE.
REQ-019 CAPTURE SHALL register mem_q into char_out.
REQ-020 From CAPTURE, a non-zero mem_q SHALL go to PRESENT; 8'h00 (NUL) SHALL go to FINISH without presenting.
REQ-021 PRESENT SHALL hold char_valid=1 and char_out stable until char_ready=1.
REQ-022 On acceptance in PRESENT, count and index SHALL increment; the next state SHALL be FINISH if index+1 = RECORD_LEN, else ISSUE.
REQ-023 FINISH SHALL assert done for exactly one cycle and return to IDLE.
REQ-024 Minimum latency SHALL be 3 cycles per character: ISSUE, CAPTURE, then PRESENT with immediate ready.
REQ-025 char_valid SHALL be high only in PRESENT; it SHALL NOT drop before acceptance.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 Address arithmetic SHALL wrap modulo 2^ADDR_W (for example, base 12'hFFE: 12'hFFE, 12'hFFF, 12'h000, ...).
REQ-028 mem_addr SHALL hold its last value outside ISSUE.

Reset
REQ-029 Asserting reset in any state SHALL force IDLE immediately.
REQ-030 Reset SHALL set char_valid=0, done=0, busy=0, count=0, char_out=8'h00, mem_addr=0 and next_addr=0.
REQ-031 A record interrupted by reset SHALL NOT produce done.
REQ-032 After reset deasserts, the block SHALL accept start on the first clock edge.

Structure
REQ-033 The FSM state encoding and the NUL constant SHALL live in a shared package used by the writer and reader blocks.
REQ-034 RECORD_LEN and ADDR_W defaults SHALL live in the same package.
REQ-035 No sub-module is required; the RAM is external and is shared with the writer through mem_addr and mem_q.

Verification
REQ-036 Full record:
- Stimulus: RAM[0x010..0x017] = "ABCDEFGH", start with begin_at=0x010, char_ready=1.
- Response: 8 chars in order, each 3 cycles apart; done pulses; count=8; next_addr=0x018.
REQ-037 Early NUL:
- Stimulus: RAM[0x020..] = "HI", 0x00.
- Response: 2 chars delivered; done pulses; count=2; next_addr=0x028; NUL never presented.
REQ-038 Backpressure:
- Stimulus: char_ready low for 5 cycles on the 2nd char.
- Response: char_out stays stable with char_valid high; no char lost or duplicated.
REQ-039 Wrap:
- Stimulus: begin_at=0xFFC, with non-zero data.
- Response: mem_addr sequence 0xFFC..0xFFF, 0x000..0x003; next_addr=0x004.
REQ-040 Reset mid-record:
- Stimulus: reset asserted during the 3rd PRESENT.
- Response: outputs take their reset values at once; no done; a new start then completes normally.
REQ-041 Start while busy:
- Stimulus: second start with a different begin_at issued mid-record.
- Response: ignored; the original record completes unchanged.
